// File: rtl/cic3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cic3_pkg
// Brief    : Shared constants and types for the CIC3 row readout block.
// Revision : 1.0 - initial release
// ============================================================================
package cic3_pkg;

  localparam int CIC3_NUM_CH = 24;
  localparam int CIC3_WORD_W = 16;

  typedef logic [CIC3_WORD_W-1:0] cic3_word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cic3_rdout_state_e;

endpackage : cic3_pkg
`default_nettype wire

// File: rtl/cic3_chan_shreg.sv
`default_nettype none
// ============================================================================
// Module   : cic3_chan_shreg
// Brief    : Per-channel MSB-first deserialiser with clear-on-frame-start.
// Revision : 1.0 - initial release
// ============================================================================
module cic3_chan_shreg
  import cic3_pkg::*;
#(
  parameter int WORD_W = CIC3_WORD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_shift_en,
  input  logic              i_clear,
  input  logic              i_bit,
  output logic [WORD_W-1:0] o_word
);

  logic [WORD_W-1:0] r_sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= {{(WORD_W-1){1'b0}}, i_bit};
    end else if (i_shift_en) begin
      r_sr <= {r_sr[WORD_W-2:0], i_bit};
    end
  end

  // Word including the bit on the wire this cycle, so the bank can load on the LSB edge
  // even when a new frame clears the register at that same edge.
  assign o_word = {r_sr[WORD_W-2:0], i_bit};

endmodule : cic3_chan_shreg
`default_nettype wire

// File: rtl/cic3_row_readout.sv
`default_nettype none
// ============================================================================
// Module   : cic3_row_readout
// Brief    : Deserialises NUM_CH serial filter results, banks them and drains
//            them one channel per handshake. CIC3_RDOUT_PARITY_EN adds out_parity.
// Revision : 1.0 - initial release
// ============================================================================
module cic3_row_readout
  import cic3_pkg::*;
#(
  parameter int NUM_CH = CIC3_NUM_CH,
  parameter int WORD_W = CIC3_WORD_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         in_bits,
  input  logic                      frame_start,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH)-1:0] out_chan,
  output logic [WORD_W-1:0]         out_data,
  output logic                      overrun,
  output logic                      frame_err
`ifdef CIC3_RDOUT_PARITY_EN
  ,
  output logic                      out_parity
`endif
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CH_W-1:0]  c_LAST_CH  = CH_W'(NUM_CH - 1);

  cic3_rdout_state_e r_state;
  cic3_rdout_state_e w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic              w_clear;
  logic              w_shift;
  logic              w_load;
  logic              w_ferr;

  logic [WORD_W-1:0] w_word [NUM_CH];
  logic [WORD_W-1:0] r_bank [NUM_CH];
  logic [CH_W-1:0]   r_ptr;
  logic              r_valid;
  logic              r_ovr;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_chan
      cic3_chan_shreg #(
        .WORD_W (WORD_W)
      ) u_shreg (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_shift_en (w_shift),
        .i_clear    (w_clear),
        .i_bit      (in_bits[g]),
        .o_word     (w_word[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_clear       = 1'b0;
    w_shift       = 1'b0;
    w_load        = 1'b0;
    w_ferr        = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_state_nxt   = SHIFT;
          w_bit_cnt_nxt = CNT_W'(1);
          w_clear       = 1'b1;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_bit_cnt == c_LAST_BIT) begin
          // A frame_start on the LSB is a legal back-to-back frame, not an error.
          w_load = 1'b1;
          if (frame_start) begin
            w_bit_cnt_nxt = CNT_W'(1);
            w_clear       = 1'b1;
          end else begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
          end
        end else if (frame_start) begin
          w_ferr        = 1'b1;
          w_bit_cnt_nxt = CNT_W'(1);
          w_clear       = 1'b1;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) r_bank[i] <= '0;
    end else if (w_load) begin
      for (int i = 0; i < NUM_CH; i++) r_bank[i] <= w_word[i];
    end
  end

  // A reload takes priority over any handshake in the same cycle so frames never mix.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_load & r_valid;
      if (w_load) begin
        r_valid <= 1'b1;
        r_ptr   <= '0;
      end else if (r_valid && out_ready) begin
        if (r_ptr == c_LAST_CH) begin
          r_valid <= 1'b0;
          r_ptr   <= '0;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_chan  = r_ptr;
  assign out_data  = r_bank[r_ptr];
  assign overrun   = r_ovr;
  assign frame_err = w_ferr;

`ifdef CIC3_RDOUT_PARITY_EN
  assign out_parity = ^out_data;
`endif

endmodule : cic3_row_readout
`default_nettype wire

// File: tb/tb_cic3_row_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic3_row_readout
// Brief    : Scoreboard bench for cic3_row_readout with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cic3_row_readout;

  localparam int NCH = 24;
  localparam int WW  = 16;
  localparam int CHW = 5;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [NCH-1:0] in_bits = '0;
  logic           frame_start = 1'b0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [CHW-1:0] out_chan;
  logic [WW-1:0]  out_data;
  logic           overrun;
  logic           frame_err;
`ifdef CIC3_RDOUT_PARITY_EN
  logic           out_parity;
`endif

  always #5 clk = ~clk;

  cic3_row_readout u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_bits     (in_bits),
    .frame_start (frame_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_chan    (out_chan),
    .out_data    (out_data),
    .overrun     (overrun),
    .frame_err   (frame_err)
`ifdef CIC3_RDOUT_PARITY_EN
    ,
    .out_parity  (out_parity)
`endif
  );

  typedef struct {
    int          cyc;
    int          ch;
    logic [15:0] d;
  } exp_t;

  exp_t        q_words[$];
  int          q_ovr[$];
  int          q_ferr[$];
  int          q_vlow[$];
  exp_t        e;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          timeouts = 0;
  bit          done = 1'b0;
  logic [15:0] fw [NCH];

  logic           p_stall = 1'b0;
  logic [CHW-1:0] p_ch = '0;
  logic [WW-1:0]  p_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every comparison in the bench happens here.
  always @(negedge clk) begin
    if (!reset_n) begin
      checks++;
      if (out_valid || out_chan != 0 || out_data != 0 || overrun || frame_err) begin
        failures++;
        $display("FAIL reset_outputs: valid=%0b chan=%0d data=%h ovr=%0b ferr=%0b, required all 0",
                 out_valid, out_chan, out_data, overrun, frame_err);
      end
`ifdef CIC3_RDOUT_PARITY_EN
      checks++;
      if (out_parity !== 1'b0) begin
        failures++;
        $display("FAIL reset_parity: got %0b required 0", out_parity);
      end
`endif
    end else begin
      if (p_stall && !overrun) begin
        checks++;
        if (!out_valid || out_chan != p_ch || out_data != p_d) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d: valid=%0b chan=%0d data=%h, required 1/%0d/%h",
                   cyc, out_valid, out_chan, out_data, p_ch, p_d);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q_words.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected cyc=%0d: chan=%0d data=%h, required no word",
                   cyc, out_chan, out_data);
        end else begin
          e = q_words.pop_front();
          if (out_chan != CHW'(e.ch) || out_data != e.d || (e.cyc >= 0 && cyc != e.cyc)) begin
            failures++;
            $display("FAIL word: chan=%0d data=%h cyc=%0d, required chan=%0d data=%h cyc=%0d",
                     out_chan, out_data, cyc, e.ch, e.d, e.cyc);
          end
`ifdef CIC3_RDOUT_PARITY_EN
          checks++;
          if (out_parity != ^e.d) begin
            failures++;
            $display("FAIL parity ch=%0d: got %0b required %0b", e.ch, out_parity, ^e.d);
          end
`endif
        end
      end
      if (overrun || (q_ovr.size() > 0 && q_ovr[0] == cyc)) begin
        checks++;
        if (!(overrun && q_ovr.size() > 0 && q_ovr[0] == cyc)) begin
          failures++;
          $display("FAIL overrun cyc=%0d: got %0b required %0b", cyc, overrun, !overrun);
        end
      end
      if (q_ovr.size() > 0 && q_ovr[0] <= cyc) void'(q_ovr.pop_front());
      if (frame_err || (q_ferr.size() > 0 && q_ferr[0] == cyc)) begin
        checks++;
        if (!(frame_err && q_ferr.size() > 0 && q_ferr[0] == cyc)) begin
          failures++;
          $display("FAIL frame_err cyc=%0d: got %0b required %0b", cyc, frame_err, !frame_err);
        end
      end
      if (q_ferr.size() > 0 && q_ferr[0] <= cyc) void'(q_ferr.pop_front());
      if (q_vlow.size() > 0 && q_vlow[0] == cyc) begin
        checks++;
        void'(q_vlow.pop_front());
        if (out_valid) begin
          failures++;
          $display("FAIL valid_low cyc=%0d: got 1 required 0", cyc);
        end
      end
    end
    p_stall = reset_n && out_valid && !out_ready;
    p_ch    = out_chan;
    p_d     = out_data;
    if (done) begin
      checks++;
      if (q_words.size() != 0 || q_ovr.size() != 0 || q_ferr.size() != 0 ||
          q_vlow.size() != 0 || timeouts != 0) begin
        failures++;
        $display("FAIL leftover: words=%0d ovr=%0d ferr=%0d vlow=%0d timeouts=%0d, required all 0",
                 q_words.size(), q_ovr.size(), q_ferr.size(), q_vlow.size(), timeouts);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [15:0] base);
    for (int k = 0; k < NCH; k++) fw[k] = base + 16'(k);
  endtask

  task automatic push_words(input int first_cyc);
    for (int k = 0; k < NCH; k++)
      q_words.push_back('{(first_cyc < 0) ? -1 : first_cyc + k, k, fw[k]});
  endtask

  task automatic send(input int nbits);
    for (int b = 0; b < nbits; b++) begin
      frame_start = (b == 0);
      for (int k = 0; k < NCH; k++) in_bits[k] = fw[k][15-b];
      tick();
    end
    frame_start = 1'b0;
    in_bits     = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q_words.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    if (q_words.size() != 0 || out_valid) begin
      timeouts++;
      $display("FAIL drain_timeout: pending=%0d valid=%0b, required 0/0", q_words.size(), out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [15:0] tmp;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Full frame, ready held high: one word per clock starting 16 cycles after frame_start.
    out_ready = 1'b1;
    set_words(16'hA500);
    t = cyc;
    push_words(t + 16);
    q_vlow.push_back(t + 40);
    send(16);
    wait_idle(60);

    // Random backpressure: order and stability under stall.
    set_words(16'h5A30);
    push_words(-1);
    send(16);
    for (int i = 0; i < 300 && (q_words.size() != 0 || out_valid); i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    wait_idle(60);

    // Second frame lands while the first is still undrained.
    out_ready = 1'b0;
    set_words(16'h1100);
    t = cyc;
    send(16);
    set_words(16'h2200);
    push_words(-1);
    q_ovr.push_back(t + 32);
    send(16);
    tick();
    out_ready = 1'b1;
    wait_idle(60);

    // frame_start five bits into a frame aborts it.
    set_words(16'h3300);
    t = cyc;
    send(5);
    set_words(16'h4400);
    q_ferr.push_back(t + 5);
    push_words(t + 21);
    q_vlow.push_back(t + 45);
    send(16);
    wait_idle(60);

    // frame_start coincident with the LSB: bank loads, new frame starts, no frame_err.
    out_ready = 1'b0;
    set_words(16'h3C00);
    t = cyc;
    send(15);
    for (int k = 0; k < 5; k++) q_words.push_back('{t + 16 + k, k, fw[k]});
    for (int k = 0; k < NCH; k++) begin
      tmp     = 16'h1230 + 16'(k);
      tmp[15] = fw[k][0];
      fw[k]   = tmp;
    end
    push_words(-1);
    q_ovr.push_back(t + 31);
    fork
      send(16);
      begin
        tick();
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
      end
    join
    out_ready = 1'b1;
    wait_idle(60);

    // Reset mid-frame, then a clean frame (parity-sensitive words 0001/0002/0003...).
    set_words(16'h7700);
    send(8);
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    set_words(16'h0001);
    t = cyc;
    push_words(t + 16);
    q_vlow.push_back(t + 40);
    send(16);
    wait_idle(60);

    repeat (3) tick();
    done = 1'b1;
    repeat (5) tick();
  end

endmodule : tb_cic3_row_readout
`default_nettype wire
